output_collect_buffer: RTL and testbench

//  Receive end of the systolic-array data stream: collects the per-row result streams leaving the PE array.

---
 rtl/obuf_pkg.sv | 20 ++
 rtl/obuf_lane.sv | 69 ++++++
 rtl/output_collect_buffer.sv | 110 +++++++++++
 tb/tb_output_collect_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obuf_pkg.sv
// ----------------------------------------------------------------------------
// obuf_pkg
//   Shared types and helpers for the output collect buffer.
//   - obuf_state_e : collect / present-tile FSM states
//   - cnt_w()      : width of a lane write counter that must reach QUEUE_LEN
// ----------------------------------------------------------------------------
package obuf_pkg;

   typedef enum logic {
      S_COLLECT  = 1'b0,
      S_DATA_OUT = 1'b1
   } obuf_state_e;

   // The counter must hold the value QUEUE_LEN itself (the "full" value),
   // hence len+1 states.
   function automatic int cnt_w(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/obuf_lane.sv
// ----------------------------------------------------------------------------
// obuf_lane
//   One result lane of the output collect buffer: a QUEUE_LEN-deep word
//   store filled in arrival order, with its write counter, full flag and
//   drop detection.
//
// Ports
//   i_clk    clock
//   i_rst    synchronous active-high reset (clears counter and stored words)
//   i_valid  a result word is present on i_data this cycle
//   i_wr_en  collection window is open (top FSM in S_COLLECT)
//   i_clr    rewind the write counter for the next tile
//   i_data   result word
//   o_full   QUEUE_LEN words have been stored
//   o_drop   i_valid this cycle but the word cannot be stored
//   o_words  stored words, o_words[k] = k-th word received
// ----------------------------------------------------------------------------
module obuf_lane
   import obuf_pkg::*;
#(
   parameter int QUEUE_LEN = 9,
   parameter int OUT_WIDTH = 32
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic                                 i_valid,
   input  logic                                 i_wr_en,
   input  logic                                 i_clr,
   input  logic [OUT_WIDTH-1:0]                 i_data,
   output logic                                 o_full,
   output logic                                 o_drop,
   output logic [QUEUE_LEN-1:0][OUT_WIDTH-1:0]  o_words
);

   localparam int CNT_W = cnt_w(QUEUE_LEN);

   logic [CNT_W-1:0] cnt;
   logic             wr;

   assign o_full = (cnt == CNT_W'(QUEUE_LEN));
   assign wr     = i_valid & i_wr_en & ~o_full;
   // Anything valid that is not written is lost: lane full, or the tile is
   // currently being presented downstream.
   assign o_drop = i_valid & ~wr;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt <= '0;
      end else if (i_clr) begin
         cnt <= '0;
      end else if (wr) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Words are not cleared between tiles; the next tile overwrites them.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_words <= '0;
      end else if (wr) begin
         for (int k = 0; k < QUEUE_LEN; k++) begin
            if (cnt == CNT_W'(k)) begin
               o_words[k] <= i_data;
            end
         end
      end
   end

endmodule

// File: rtl/output_collect_buffer.sv
// ----------------------------------------------------------------------------
// output_collect_buffer
//   Receive end of the systolic-array result stream. Each PE-array row
//   delivers its results on its own lane, skewed by one cycle per row. Every
//   lane fills independently; once all lanes hold QUEUE_LEN words the
//   de-skewed QUEUE_NUM x QUEUE_LEN tile is offered downstream with a
//   valid/ready handshake, after which collection re-arms.
//
// Ports
//   i_clk            clock
//   i_rst            synchronous active-high reset
//   i_valid          per-lane result valid
//   i_data           per-lane result word
//   o_collect_ready  high while collecting (informational, array cannot stall)
//   o_post_valid     a complete tile is on o_data
//   i_post_ready     downstream accepts the tile
//   o_data           o_data[i][k] = k-th word received on lane i
//   o_data_out_done  one-cycle pulse on the tile handshake
//   o_overflow       sticky: some valid word was dropped
// ----------------------------------------------------------------------------
module output_collect_buffer
   import obuf_pkg::*;
#(
   parameter int QUEUE_NUM = 3,
   parameter int QUEUE_LEN = 9,
   parameter int OUT_WIDTH = 32
) (
   input  logic                                                i_clk,
   input  logic                                                i_rst,
   input  logic [QUEUE_NUM-1:0]                                i_valid,
   input  logic [QUEUE_NUM-1:0][OUT_WIDTH-1:0]                 i_data,
   output logic                                                o_collect_ready,
   output logic                                                o_post_valid,
   input  logic                                                i_post_ready,
   output logic [QUEUE_NUM-1:0][QUEUE_LEN-1:0][OUT_WIDTH-1:0]  o_data,
   output logic                                                o_data_out_done,
   output logic                                                o_overflow
);

   obuf_state_e          state;
   logic [QUEUE_NUM-1:0] full;
   logic [QUEUE_NUM-1:0] drop;
   logic                 all_full;
   logic                 collecting;
   logic                 fire;

   assign collecting = (state == S_COLLECT);
   assign all_full   = &full;
   // A reset cycle never counts as a handshake.
   assign fire            = o_post_valid & i_post_ready & ~i_rst;
   assign o_data_out_done = fire;

   for (genvar g = 0; g < QUEUE_NUM; g++) begin : g_lane
      obuf_lane #(
         .QUEUE_LEN (QUEUE_LEN),
         .OUT_WIDTH (OUT_WIDTH)
      ) u_lane (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_valid (i_valid[g]),
         .i_wr_en (collecting),
         .i_clr   (fire),
         .i_data  (i_data[g]),
         .o_full  (full[g]),
         .o_drop  (drop[g]),
         .o_words (o_data[g])
      );
   end

   // Tile FSM. all_full comes from registered lane counters, so the tile is
   // offered one edge after the last word lands.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= S_COLLECT;
         o_post_valid    <= 1'b0;
         o_collect_ready <= 1'b1;
      end else begin
         case (state)
            S_COLLECT: begin
               if (all_full) begin
                  state           <= S_DATA_OUT;
                  o_post_valid    <= 1'b1;
                  o_collect_ready <= 1'b0;
               end
            end
            S_DATA_OUT: begin
               if (fire) begin
                  state           <= S_COLLECT;
                  o_post_valid    <= 1'b0;
                  o_collect_ready <= 1'b1;
               end
            end
            default: begin
               state           <= S_COLLECT;
               o_post_valid    <= 1'b0;
               o_collect_ready <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_overflow <= 1'b0;
      end else if (|drop) begin
         o_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_output_collect_buffer.sv
// ----------------------------------------------------------------------------
// tb_output_collect_buffer
//   Self-checking bench for output_collect_buffer (3 lanes x 9 words x 32b).
//   A lane-queue model tracks stored words, tile presentation and overflow;
//   every cycle the DUT outputs are compared against it. Directed scenarios
//   are followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_output_collect_buffer;

   localparam int QN = 3;
   localparam int QL = 9;
   localparam int W  = 32;

   logic                           i_clk = 1'b0;
   logic                           i_rst = 1'b1;
   logic [QN-1:0]                  i_valid = '0;
   logic [QN-1:0][W-1:0]           i_data = '0;
   logic                           o_collect_ready;
   logic                           o_post_valid;
   logic                           i_post_ready = 1'b0;
   logic [QN-1:0][QL-1:0][W-1:0]   o_data;
   logic                           o_data_out_done;
   logic                           o_overflow;

   output_collect_buffer #(
      .QUEUE_NUM (QN),
      .QUEUE_LEN (QL),
      .OUT_WIDTH (W)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_valid         (i_valid),
      .i_data          (i_data),
      .o_collect_ready (o_collect_ready),
      .o_post_valid    (o_post_valid),
      .i_post_ready    (i_post_ready),
      .o_data          (o_data),
      .o_data_out_done (o_data_out_done),
      .o_overflow      (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   // ---------------- model state ----------------
   logic [W-1:0] m_word [QN][QL];
   int           m_cnt  [QN];
   bit           m_pv;
   bit           m_ovf;

   int  n_checks = 0;
   int  n_fail   = 0;
   int  done_cnt = 0;
   bit  chk_en   = 0;

   task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a lane accepts a word only while no tile is being presented and
   // it holds fewer than QL words; anything else is dropped. The tile is
   // offered on the edge after all lanes were seen full, and taken away with
   // all lanes emptied on an accepted handshake.
   task automatic model_update();
      bit prev_full;
      if (i_rst) begin
         m_pv  = 0;
         m_ovf = 0;
         for (int i = 0; i < QN; i++) begin
            m_cnt[i] = 0;
            for (int k = 0; k < QL; k++) m_word[i][k] = '0;
         end
      end else begin
         prev_full = 1;
         for (int i = 0; i < QN; i++) if (m_cnt[i] != QL) prev_full = 0;
         for (int i = 0; i < QN; i++) begin
            if (i_valid[i]) begin
               if (!m_pv && m_cnt[i] < QL) begin
                  m_word[i][m_cnt[i]] = i_data[i];
                  m_cnt[i]++;
               end else begin
                  m_ovf = 1;
               end
            end
         end
         if (m_pv && i_post_ready) begin
            m_pv = 0;
            for (int i = 0; i < QN; i++) m_cnt[i] = 0;
         end else if (!m_pv && prev_full) begin
            m_pv = 1;
         end
      end
   endtask

   task automatic check_outputs();
      cmp("post_valid", W'(o_post_valid), W'(m_pv));
      cmp("collect_ready", W'(o_collect_ready), W'(!m_pv));
      cmp("overflow", W'(o_overflow), W'(m_ovf));
      cmp("done", W'(o_data_out_done), W'(m_pv && i_post_ready && !i_rst));
      for (int i = 0; i < QN; i++)
         for (int k = 0; k < QL; k++)
            cmp($sformatf("data[%0d][%0d]", i, k), o_data[i][k], m_word[i][k]);
   endtask

   // One clock: settle, compare, take the edge, advance the model.
   task automatic tick();
      #1;
      if (chk_en) begin
         check_outputs();
         if (o_data_out_done) done_cnt++;
      end
      @(posedge i_clk);
      model_update();
      #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      i_valid      = '0;
      i_post_ready = rdy;
      for (int c = 0; c < n; c++) tick();
   endtask

   task automatic do_reset();
      i_rst   = 1'b1;
      i_valid = '0;
      tick();
      i_rst = 1'b0;
   endtask

   // Fill all lanes in lockstep with random words.
   task automatic fill_all(input int n, input logic rdy);
      i_post_ready = rdy;
      for (int c = 0; c < n; c++) begin
         i_valid = '1;
         for (int i = 0; i < QN; i++) i_data[i] = $urandom;
         tick();
      end
      i_valid = '0;
   endtask

   initial begin
      // ---------------- reset ----------------
      i_rst = 1'b1;
      tick();
      tick();
      chk_en = 1;
      i_rst  = 1'b0;
      cmp("rst_post_valid", W'(o_post_valid), 0);
      cmp("rst_collect_ready", W'(o_collect_ready), 1);
      cmp("rst_overflow", W'(o_overflow), 0);
      cmp("rst_data", o_data[1][4], 0);

      // ---------------- skewed fill, ready high ----------------
      done_cnt     = 0;
      i_post_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < QN; i++) begin
            i_valid[i] = (c >= i) && (c < i + QL);
            i_data[i]  = W'(100 * i + (c - i));
         end
         tick();
      end
      i_valid = '0;
      cmp("skew_d28", o_data[2][8], 208);
      cmp("skew_d00", o_data[0][0], 0);
      cmp("skew_d13", o_data[1][3], 103);
      cmp("skew_model_d28", m_word[2][8], 208);
      cmp("skew_done_pulses", W'(done_cnt), 1);
      cmp("skew_overflow", W'(o_overflow), 0);

      // ---------------- backpressure ----------------
      done_cnt = 0;
      fill_all(QL, 1'b0);
      idle(7, 1'b0);
      cmp("bp_post_valid_held", W'(o_post_valid), 1);
      cmp("bp_no_done_yet", W'(done_cnt), 0);
      idle(1, 1'b1);
      cmp("bp_done_pulses", W'(done_cnt), 1);
      cmp("bp_collect_ready", W'(o_collect_ready), 1);

      // ---------------- overflow on lane 0 while others fill ----------------
      done_cnt     = 0;
      i_post_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
         i_valid[0] = (c < QL + 1);
         i_data[0]  = W'(500 + c);
         for (int i = 1; i < QN; i++) begin
            i_valid[i] = (c >= 3) && (c < 3 + QL);
            i_data[i]  = $urandom;
         end
         tick();
      end
      i_valid = '0;
      cmp("ovf_d08", o_data[0][8], 508);
      cmp("ovf_sticky", W'(o_overflow), 1);
      cmp("ovf_done_pulses", W'(done_cnt), 1);

      // ---------------- valid during tile presentation ----------------
      do_reset();
      fill_all(QL, 1'b0);
      i_valid = '1;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < QN; i++) i_data[i] = 32'hDEAD_0000 + W'(c);
         tick();
      end
      i_valid = '0;
      cmp("dout_overflow", W'(o_overflow), 1);
      cmp("dout_post_valid", W'(o_post_valid), 1);
      idle(2, 1'b1);

      // ---------------- reset mid-tile ----------------
      fill_all(4, 1'b0);
      do_reset();
      i_post_ready = 1'b0;
      for (int c = 0; c < QL; c++) begin
         i_valid = '1;
         for (int i = 0; i < QN; i++) i_data[i] = W'(900 + 10 * i + c);
         tick();
      end
      i_valid = '0;
      cmp("rmt_no_early_valid", W'(o_post_valid), 0);
      idle(1, 1'b0);
      cmp("rmt_post_valid", W'(o_post_valid), 1);
      cmp("rmt_d10", o_data[1][0], 910);
      cmp("rmt_overflow", W'(o_overflow), 0);
      idle(2, 1'b1);

      // ---------------- back-to-back tiles ----------------
      done_cnt = 0;
      fill_all(QL, 1'b1);
      i_post_ready = 1'b1;
      begin
         int guard = 0;
         while (!m_pv && guard < 10) begin
            tick();
            guard++;
         end
         cmp("b2b_tile1_offered", W'(m_pv), 1);
      end
      tick();  // handshake cycle
      fill_all(QL, 1'b1);
      idle(3, 1'b1);
      cmp("b2b_done_pulses", W'(done_cnt), 2);
      cmp("b2b_overflow", W'(o_overflow), 0);

      // ---------------- randomized ----------------
      for (int c = 0; c < 600; c++) begin
         i_rst        = ($urandom_range(0, 99) == 0);
         i_post_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < QN; i++) begin
            i_valid[i] = ($urandom_range(0, 2) != 0);
            i_data[i]  = $urandom;
         end
         tick();
      end
      i_rst   = 1'b0;
      i_valid = '0;
      idle(3, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
